// File: rtl/sap_datapath.sv
// SAP-1 style datapath: 8-bit shared bus, PC, MAR, IR, A/B registers, adder/subtractor,
// 16x8 program RAM and status flags, sequenced by an external 12-bit control word.
module sap_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ctrl,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [3:0]  opcode,
  output logic [7:0]  bus,
  output logic [3:0]  pc,
  output logic [3:0]  mar,
  output logic [7:0]  a_reg,
  output logic [7:0]  b_reg,
  output logic        carry,
  output logic        zero,
  output logic        halted,
  output logic        bus_conflict
);

  localparam int HLT       = 11;
  localparam int PC_INC    = 10;
  localparam int PC_EN     = 9;
  localparam int MEM_LOAD  = 8;
  localparam int MEM_EN    = 7;
  localparam int IR_LOAD   = 6;
  localparam int IR_EN     = 5;
  localparam int A_LOAD    = 4;
  localparam int A_EN      = 3;
  localparam int B_LOAD    = 2;
  localparam int ADDER_SUB = 1;
  localparam int ADDER_EN  = 0;

  logic [7:0] r_ram [16];
  logic [3:0] r_pc;
  logic [3:0] r_mar;
  logic [7:0] r_ir;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_carry;
  logic       r_zero;
  logic       r_halted;
  logic       r_conflict;

  logic [8:0] w_sum;
  logic [7:0] w_alu;
  logic [7:0] w_mem;
  logic [7:0] w_bus;
  logic [2:0] w_en_cnt;

  // Two's-complement subtract as a + ~b + 1; bit 8 is the carry out of the 9-bit sum.
  function automatic logic [8:0] alu_sum(input logic [7:0] a, input logic [7:0] b,
                                         input logic sub);
    logic [7:0] b_op;
    b_op = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_op} + {8'h00, sub};
  endfunction

  assign w_sum    = alu_sum(r_a, r_b, ctrl[ADDER_SUB]);
  assign w_alu    = w_sum[7:0];
  assign w_mem    = r_ram[r_mar];
  assign w_en_cnt = {2'b00, ctrl[PC_EN]} + {2'b00, ctrl[MEM_EN]} + {2'b00, ctrl[IR_EN]}
                  + {2'b00, ctrl[A_EN]} + {2'b00, ctrl[ADDER_EN]};

  // Bus is forced idle during reset so no output depends on ctrl while rst is low.
  always_comb begin
    w_bus = 8'h00;
    if (rst) begin
      if (ctrl[PC_EN])         w_bus = {4'h0, r_pc};
      else if (ctrl[MEM_EN])   w_bus = w_mem;
      else if (ctrl[IR_EN])    w_bus = {4'h0, r_ir[3:0]};
      else if (ctrl[A_EN])     w_bus = r_a;
      else if (ctrl[ADDER_EN]) w_bus = w_alu;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= 4'h0;
      r_mar      <= 4'h0;
      r_ir       <= 8'h00;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_halted   <= 1'b0;
      r_conflict <= 1'b0;
    end else if (!r_halted) begin
      if (ctrl[PC_INC])   r_pc  <= r_pc + 4'h1;
      if (ctrl[MEM_LOAD]) r_mar <= w_bus[3:0];
      if (ctrl[IR_LOAD])  r_ir  <= w_bus;
      if (ctrl[A_LOAD])   r_a   <= w_bus;
      if (ctrl[B_LOAD])   r_b   <= w_bus;
      if (ctrl[ADDER_EN] && ctrl[A_LOAD]) begin
        r_carry <= w_sum[8];
        r_zero  <= (w_alu == 8'h00);
      end
      if (w_en_cnt > 3'd1) r_conflict <= 1'b1;
      if (ctrl[HLT])       r_halted   <= 1'b1;
    end
  end

  // Program port is outside the reset/halt domain so code can be loaded at any time.
  always_ff @(posedge clk) begin
    if (prog_we) r_ram[prog_addr] <= prog_data;
  end

  assign opcode       = r_ir[7:4];
  assign bus          = w_bus;
  assign pc           = r_pc;
  assign mar          = r_mar;
  assign a_reg        = r_a;
  assign b_reg        = r_b;
  assign carry        = r_carry;
  assign zero         = r_zero;
  assign halted       = r_halted;
  assign bus_conflict = r_conflict;

endmodule

// File: tb/tb_sap_datapath.sv
// Bench for sap_datapath: a table of consecutive control words plus hand-written
// halt, PC-wrap, bus-conflict and program-write sequences, checked through a scoreboard.
module tb_sap_datapath;

  localparam logic [11:0] C_HLT    = 12'h800;
  localparam logic [11:0] C_PC_INC = 12'h400;
  localparam logic [11:0] C_PC_EN  = 12'h200;
  localparam logic [11:0] C_MEM_LD = 12'h100;
  localparam logic [11:0] C_MEM_EN = 12'h080;
  localparam logic [11:0] C_IR_LD  = 12'h040;
  localparam logic [11:0] C_A_LD   = 12'h010;
  localparam logic [11:0] C_A_EN   = 12'h008;
  localparam logic [11:0] C_B_LD   = 12'h004;
  localparam logic [11:0] C_ADD_EN = 12'h001;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ctrl;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  bus;
  logic [3:0]  pc;
  logic [3:0]  mar;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic        carry;
  logic        zero;
  logic        halted;
  logic        bus_conflict;

  typedef struct {
    string      nm;
    logic [3:0] pc;
    logic [3:0] mar;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       z;
    logic       h;
    logic       bc;
  } st_t;

  typedef struct {
    string       nm;
    logic [11:0] ctrl;
    logic [7:0]  bus;
    logic [3:0]  pc;
    logic [3:0]  mar;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic        z;
  } vec_t;

  st_t  e;
  st_t  sbq[$];
  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  sap_datapath dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .opcode(opcode), .bus(bus), .pc(pc), .mar(mar),
    .a_reg(a_reg), .b_reg(b_reg), .carry(carry), .zero(zero), .halted(halted),
    .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_e();
    e.pc = 4'h0; e.mar = 4'h0; e.op = 4'h0; e.a = 8'h00; e.b = 8'h00;
    e.c = 1'b0; e.z = 1'b0; e.h = 1'b0; e.bc = 1'b0;
  endtask

  task automatic check_out();
    st_t x;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got no expected entry, expected one queued");
      return;
    end
    x = sbq.pop_front();
    cmp({x.nm, ".pc"},     {4'h0, pc},        {4'h0, x.pc});
    cmp({x.nm, ".mar"},    {4'h0, mar},       {4'h0, x.mar});
    cmp({x.nm, ".opcode"}, {4'h0, opcode},    {4'h0, x.op});
    cmp({x.nm, ".a_reg"},  a_reg,             x.a);
    cmp({x.nm, ".b_reg"},  b_reg,             x.b);
    cmp({x.nm, ".carry"},  {7'h0, carry},     {7'h0, x.c});
    cmp({x.nm, ".zero"},   {7'h0, zero},      {7'h0, x.z});
    cmp({x.nm, ".halted"}, {7'h0, halted},    {7'h0, x.h});
    cmp({x.nm, ".bconf"},  {7'h0, bus_conflict}, {7'h0, x.bc});
  endtask

  // Called at posedge+1; e must already hold the state expected after this edge.
  task automatic run(input string nm, input logic [11:0] c, input bit chk_bus,
                     input logic [7:0] ebus);
    ctrl = c;
    #1;
    if (chk_bus) cmp({nm, ".bus"}, bus, ebus);
    e.nm = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset(input logic [11:0] c);
    rst  = 1'b0;
    ctrl = c;
    #1;
    cmp("reset.bus", bus, 8'h00);
    clr_e();
    e.nm = "reset";
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_out();
    rst = 1'b1;
  endtask

  task automatic prog(input logic [3:0] ad, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = ad; prog_data = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  task automatic add_vec(input string nm, input logic [11:0] c, input logic [7:0] eb,
                         input logic [3:0] p, input logic [3:0] m, input logic [3:0] o,
                         input logic [7:0] a, input logic [7:0] b, input logic cy,
                         input logic z);
    vec_t v;
    v.nm = nm; v.ctrl = c; v.bus = eb; v.pc = p; v.mar = m; v.op = o;
    v.a = a; v.b = b; v.c = cy; v.z = z;
    tv.push_back(v);
  endtask

  initial begin
    rst = 1'b0; ctrl = 12'h000; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    clr_e();

    //            name          ctrl                    bus    pc    mar   op    a      b      c     z
    add_vec("fetch0_mar", C_PC_EN | C_MEM_LD,           8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    add_vec("fetch0_inc", C_PC_INC,                     8'h00, 4'h1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    add_vec("fetch0_ir",  C_MEM_EN | C_IR_LD,           8'h1E, 4'h1, 4'h0, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0);
    add_vec("ir_to_mar0", 12'h020 | C_MEM_LD,           8'h0E, 4'h1, 4'hE, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0);
    add_vec("lda_f0",     C_MEM_EN | C_A_LD,            8'hF0, 4'h1, 4'hE, 4'h1, 8'hF0, 8'h00, 1'b0, 1'b0);
    add_vec("fetch1_mar", C_PC_EN | C_MEM_LD,           8'h01, 4'h1, 4'h1, 4'h1, 8'hF0, 8'h00, 1'b0, 1'b0);
    add_vec("fetch1_inc", C_PC_INC,                     8'h00, 4'h2, 4'h1, 4'h1, 8'hF0, 8'h00, 1'b0, 1'b0);
    add_vec("fetch1_ir",  C_MEM_EN | C_IR_LD,           8'h2F, 4'h2, 4'h1, 4'h2, 8'hF0, 8'h00, 1'b0, 1'b0);
    add_vec("ir_to_mar1", 12'h020 | C_MEM_LD,           8'h0F, 4'h2, 4'hF, 4'h2, 8'hF0, 8'h00, 1'b0, 1'b0);
    add_vec("ldb_20",     C_MEM_EN | C_B_LD,            8'h20, 4'h2, 4'hF, 4'h2, 8'hF0, 8'h20, 1'b0, 1'b0);
    add_vec("add_carry",  C_ADD_EN | C_A_LD,            8'h10, 4'h2, 4'hF, 4'h2, 8'h10, 8'h20, 1'b1, 1'b0);
    add_vec("sub_borrow", 12'h002 | C_ADD_EN | C_A_LD,  8'hF0, 4'h2, 4'hF, 4'h2, 8'hF0, 8'h20, 1'b0, 1'b0);
    add_vec("mar_pc2",    C_PC_EN | C_MEM_LD,           8'h02, 4'h2, 4'h2, 4'h2, 8'hF0, 8'h20, 1'b0, 1'b0);
    add_vec("lda_05",     C_MEM_EN | C_A_LD,            8'h05, 4'h2, 4'h2, 4'h2, 8'h05, 8'h20, 1'b0, 1'b0);
    add_vec("ldb_05",     C_MEM_EN | C_B_LD,            8'h05, 4'h2, 4'h2, 4'h2, 8'h05, 8'h05, 1'b0, 1'b0);
    add_vec("sub_zero",   12'h002 | C_ADD_EN | C_A_LD,  8'h00, 4'h2, 4'h2, 4'h2, 8'h00, 8'h05, 1'b1, 1'b1);
    add_vec("alu_noload", C_ADD_EN,                     8'h05, 4'h2, 4'h2, 4'h2, 8'h00, 8'h05, 1'b1, 1'b1);
    add_vec("ldb_idle",   C_B_LD,                       8'h00, 4'h2, 4'h2, 4'h2, 8'h00, 8'h00, 1'b1, 1'b1);
    add_vec("add_zero",   C_ADD_EN | C_A_LD,            8'h00, 4'h2, 4'h2, 4'h2, 8'h00, 8'h00, 1'b0, 1'b1);

    @(posedge clk);
    #1;
    prog(4'h0, 8'h1E);
    prog(4'h1, 8'h2F);
    prog(4'h2, 8'h05);
    prog(4'hE, 8'hF0);
    prog(4'hF, 8'h20);

    do_reset(C_HLT | C_PC_INC | C_PC_EN | C_A_LD);
    do_reset(C_HLT | C_PC_INC | C_PC_EN | C_A_LD);

    foreach (tv[i]) begin
      e.pc = tv[i].pc; e.mar = tv[i].mar; e.op = tv[i].op; e.a = tv[i].a; e.b = tv[i].b;
      e.c = tv[i].c; e.z = tv[i].z; e.h = 1'b0; e.bc = 1'b0;
      run(tv[i].nm, tv[i].ctrl, 1'b1, tv[i].bus);
    end

    // Halt: actions in the HLT word still apply, then everything freezes until reset.
    do_reset(12'h000);
    for (int i = 0; i < 3; i++) begin
      e.pc = 4'(i + 1);
      run("halt_pre_inc", C_PC_INC, 1'b1, 8'h00);
    end
    e.pc = 4'h4; e.h = 1'b1;
    run("halt_edge", C_HLT | C_PC_INC, 1'b0, 8'h00);
    run("halted_frozen", C_PC_INC | C_PC_EN | C_A_LD, 1'b1, 8'h04);
    run("halted_noconf", C_PC_EN | C_A_EN | C_MEM_LD, 1'b1, 8'h04);
    do_reset(C_HLT | C_PC_INC);
    e.pc = 4'h1;
    run("post_reset_inc", C_PC_INC, 1'b0, 8'h00);

    // PC wraps from F back to 0.
    do_reset(12'h000);
    for (int i = 0; i < 16; i++) begin
      e.pc = 4'(i + 1);
      run("pc_wrap", C_PC_INC, 1'b0, 8'h00);
    end

    // Bus conflict: PC wins the bus, flag is sticky until reset.
    do_reset(12'h000);
    for (int i = 0; i < 7; i++) begin
      e.pc = 4'(i + 1);
      run("conf_pre_inc", C_PC_INC, 1'b0, 8'h00);
    end
    e.a = 8'h07; e.bc = 1'b1;
    run("conflict", C_PC_EN | C_A_EN | C_A_LD, 1'b1, 8'h07);
    run("conf_sticky", 12'h000, 1'b1, 8'h00);
    e.b = 8'h07;
    run("a_to_b", C_A_EN | C_B_LD, 1'b1, 8'h07);
    run("a_over_alu", C_A_EN | C_ADD_EN | C_B_LD, 1'b1, 8'h07);
    do_reset(12'h000);

    // Program write to the address under MAR: old data this cycle, new data next cycle.
    prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h5A;
    e.a = 8'h1E;
    run("wr_same_cycle", C_MEM_EN | C_A_LD, 1'b1, 8'h1E);
    prog_we = 1'b0;
    e.b = 8'h5A;
    run("wr_next_cycle", C_MEM_EN | C_B_LD, 1'b1, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
